// File: rtl/mem_row_arb_pkg.sv
// mem_row_arb_pkg: shared defaults, pixel geometry and FSM state type for the pixel-row arbiter
package mem_row_arb_pkg;
  localparam int ADDR_WIDTH_DEF = 11;
  localparam int ROW_WIDTH_DEF = 64;
  localparam int PIXELS_PER_ROW = 16;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, RESP} arb_state_t;
endpackage

// File: rtl/mem_row_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set req bit after rr_ptr (wrapping)
module rr_pick
  import mem_row_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               any,
  output logic [IW-1:0]      winner
);
  logic [IW-1:0] idx;
  assign any = |req;
  always_comb begin
    idx = '0;
    winner = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/mem_row_arbiter.sv
// mem_row_arbiter: round-robin SRAM row-read arbiter; MEM_ROW_ARB_LAST_ROW_HIT_EN adds a one-row cache
module mem_row_arbiter
  import mem_row_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ROW_WIDTH = ROW_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [ROW_WIDTH-1:0]          rsp_data,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          mem_csb,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [ROW_WIDTH-1:0]          mem_data_out,
  input  logic                          data_ready_mem
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  arb_state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d, win_oh;
  logic [ROW_WIDTH-1:0] rsp_data_q, rsp_data_d, hit_row;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d, win_addr;
  logic rsp_err_q, rsp_err_d, mem_csb_q, mem_csb_d, mem_we_q, mem_we_d;
  logic any, hit, tmo;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req), .rr_ptr(rr_ptr_q), .any(any), .winner(win)
  );

  assign win_addr = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_oh = NUM_REQ'(1) << win;
  assign tmo = TIMEOUT_CYCLES != 0 && int'(cnt_q) == TIMEOUT_CYCLES - 1;

`ifdef MEM_ROW_ARB_LAST_ROW_HIT_EN
  logic cache_vld_q, cache_vld_d, fill;
  logic [ADDR_WIDTH-1:0] cache_tag_q, cache_tag_d;
  logic [ROW_WIDTH-1:0] cache_row_q, cache_row_d;
  assign fill = state_q == WAIT_MEM && data_ready_mem;
  assign hit = cache_vld_q && cache_tag_q == win_addr;
  assign hit_row = cache_row_q;
  always_comb begin
    cache_vld_d = fill | (cache_vld_q & ~(state_q == WAIT_MEM & tmo));
    cache_tag_d = fill ? mem_addr_q : cache_tag_q;
    cache_row_d = fill ? mem_data_out : cache_row_q;
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld_q <= 1'b0;
      cache_tag_q <= '0;
      cache_row_q <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_tag_q <= cache_tag_d;
      cache_row_q <= cache_row_d;
    end
  end
`else
  assign hit = 1'b0;
  assign hit_row = '0;
`endif

  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    rsp_valid_d = '0;
    rsp_data_d = rsp_data_q;
    rsp_err_d = 1'b0;
    mem_csb_d = mem_csb_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: if (any) begin
        gnt_d = win_oh;
        rr_ptr_d = win;
        cnt_d = '0;
        if (hit) begin
          rsp_valid_d = win_oh;
          rsp_data_d = hit_row;
          state_d = RESP;
        end else begin
          mem_addr_d = win_addr;
          mem_csb_d = 1'b0;
          mem_we_d = 1'b1;
          state_d = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        cnt_d = cnt_q + 1'b1;
        // a data strobe in the timeout cycle still returns good data
        if (data_ready_mem || tmo) begin
          rsp_valid_d = gnt_q;
          rsp_data_d = data_ready_mem ? mem_data_out : '0;
          rsp_err_d = !data_ready_mem;
          mem_csb_d = 1'b1;
          mem_we_d = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        gnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= IW'(NUM_REQ - 1);
      cnt_q <= '0;
      gnt_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      mem_csb_q <= 1'b1;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      mem_csb_q <= mem_csb_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign gnt = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign busy = state_q != IDLE;
  assign mem_csb = mem_csb_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
endmodule

// File: tb/tb_mem_row_arbiter.sv
// tb_mem_row_arbiter: directed and random checks of mem_row_arbiter against a transaction-level model
module tb_mem_row_arbiter;
  localparam int NR = 4;
  localparam int AW = 11;
  localparam int RW = 64;
  localparam int TMO = 16;
`ifdef MEM_ROW_ARB_LAST_ROW_HIT_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0] gnt, rsp_valid;
  logic [RW-1:0] rsp_data;
  logic rsp_err, busy, mem_csb, mem_we;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_data_out = '0;
  logic data_ready_mem = 1'b0;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int dmode = 2;
  bit spur = 1'b0;

  mem_row_arbiter dut (
    .clock(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .mem_csb(mem_csb), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .data_ready_mem(data_ready_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] row_of(input logic [AW-1:0] a);
    return (a == 11'd5) ? 64'hFEDC_BA98_7654_3210 : {a, a, a, a, a, 9'h0} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=no_event expected=event_within_bound t=%0t", nm, $time);
  endtask

  task automatic wait_rsp(input string nm, input int lim, output int lowc);
    int k = 0;
    lowc = 0;
    while (rsp_valid === '0 && k < lim) begin
      lowc += int'(mem_csb === 1'b0);
      @(negedge clk);
      k++;
    end
    if (k >= lim) bound_fail(nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Memory model: data strobe dly+1 cycles into an access (dly<0 never), optional stray strobes when idle
  initial begin
    int wcnt = 0, cur_dly = 0;
    forever begin
      @(negedge clk);
      if (mem_csb === 1'b0) begin
        if (wcnt == 0) cur_dly = (dmode == -2) ? int'($urandom_range(0, 18)) : dmode;
        wcnt++;
        data_ready_mem = cur_dly >= 0 && wcnt == cur_dly + 1;
      end else begin
        wcnt = 0;
        data_ready_mem = spur && $urandom_range(0, 2) == 0;
      end
      mem_data_out = row_of(mem_addr);
    end
  end

  // Transaction-level reference: who owns the memory, how long it has waited, last response row
  logic [NR-1:0] e_gnt = '0, e_rsp_valid = '0;
  logic [RW-1:0] e_rsp_data = '0;
  logic e_rsp_err = 1'b0, e_busy = 1'b0, e_csb = 1'b1, e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  int m_owner = -1, m_wait = 0, m_ptr = NR - 1;
  bit m_resp = 1'b0;
  bit c_vld = 1'b0;
  logic [AW-1:0] c_tag = '0;
  logic [RW-1:0] c_row = '0;

  initial begin
    int w;
    logic [AW-1:0] a;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e_gnt = '0; e_rsp_valid = '0; e_rsp_data = '0; e_rsp_err = 1'b0;
        e_csb = 1'b1; e_we = 1'b0; e_addr = '0;
        m_owner = -1; m_wait = 0; m_ptr = NR - 1; m_resp = 1'b0; c_vld = 1'b0;
      end else if (m_resp) begin
        e_gnt = '0; e_rsp_valid = '0; e_rsp_err = 1'b0; m_resp = 1'b0;
      end else if (m_owner >= 0) begin
        m_wait++;
        if (data_ready_mem) begin
          e_rsp_valid = NR'(1) << m_owner; e_rsp_data = mem_data_out; e_rsp_err = 1'b0;
          e_csb = 1'b1; e_we = 1'b0; m_resp = 1'b1; m_owner = -1;
          c_vld = 1'b1; c_tag = e_addr; c_row = mem_data_out;
        end else if (TMO != 0 && m_wait == TMO) begin
          e_rsp_valid = NR'(1) << m_owner; e_rsp_data = '0; e_rsp_err = 1'b1;
          e_csb = 1'b1; e_we = 1'b0; m_resp = 1'b1; m_owner = -1; c_vld = 1'b0;
        end
      end else begin
        w = -1;
        for (int k = 1; k <= NR; k++) if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        if (w >= 0) begin
          a = req_addr[w*AW +: AW];
          m_ptr = w;
          e_gnt = NR'(1) << w;
          if (CACHE && c_vld && c_tag == a) begin
            e_rsp_valid = NR'(1) << w; e_rsp_data = c_row; m_resp = 1'b1;
          end else begin
            m_owner = w; m_wait = 0; e_csb = 1'b0; e_we = 1'b1; e_addr = a;
          end
        end
      end
      e_busy = m_resp || m_owner >= 0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
        chk("rsp_data", rsp_data, e_rsp_data);
        chk("rsp_err", 64'(rsp_err), 64'(e_rsp_err));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("mem_csb", 64'(mem_csb), 64'(e_csb));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      end
    end
  end

  initial begin
    int lowc, pulses, k;
    logic [3:0] g_q[$];
    logic [AW-1:0] a_q[$];
    logic prev_csb, prev_g;
    logic [63:0] first_row;
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int exp_a [5] = '{10, 20, 30, 40, 10};
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_csb", 64'(mem_csb), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_addr", 64'(mem_addr), 64'h0);
    rst_n = 1'b1;

    req_addr[0 +: AW] = 11'h005;
    req = 4'b0001;
    dmode = 2;
    wait_rsp("t1_rsp", 50, lowc);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_rsp_data", rsp_data, 64'hFEDC_BA98_7654_3210);
    chk("t1_rsp_err", 64'(rsp_err), 64'h0);
    chk("t1_mem_addr", 64'(mem_addr), 64'h5);
    chk("t1_csb_cycles", 64'(lowc), 64'd3);
    req = '0;
    @(negedge clk);
    chk("t1_one_strobe", 64'(rsp_valid), 64'h0);
    repeat (3) @(negedge clk);

    do_reset();
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'(10 * (i + 1));
    req = 4'b1111;
    dmode = 1;
    prev_csb = 1'b1;
    prev_g = 1'b0;
    k = 0;
    while (g_q.size() < 5 && k < 300) begin
      @(negedge clk);
      if (gnt != '0 && !prev_g) g_q.push_back(gnt);
      if (!mem_csb && prev_csb) a_q.push_back(mem_addr);
      prev_g = gnt != '0;
      prev_csb = mem_csb;
      k++;
    end
    if (g_q.size() < 5 || a_q.size() < 5) bound_fail("t2_order");
    else for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_gnt%0d", i), 64'(g_q[i]), 64'(exp_g[i]));
      chk($sformatf("t2_addr%0d", i), 64'(a_q[i]), 64'(exp_a[i]));
    end
    req = '0;
    repeat (8) @(negedge clk);

    req_addr[1*AW +: AW] = 11'd33;
    req = 4'b0010;
    dmode = -1;
    wait_rsp("t3_rsp", 60, lowc);
    chk("t3_wait_cycles", 64'(lowc), 64'd16);
    chk("t3_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("t3_rsp_err", 64'(rsp_err), 64'h1);
    chk("t3_rsp_data", rsp_data, 64'h0);
    chk("t3_csb", 64'(mem_csb), 64'h1);
    req = '0;
    repeat (3) @(negedge clk);

    req_addr[2*AW +: AW] = 11'd50;
    req = 4'b0100;
    repeat (4) @(negedge clk);
    chk("t4_in_wait", 64'(mem_csb), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_csb", 64'(mem_csb), 64'h1);
    chk("t4_rst_gnt", 64'(gnt), 64'h0);
    chk("t4_rst_rsp", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dmode = 1;
    wait_rsp("t4_rsp", 30, lowc);
    chk("t4_reserve", 64'(rsp_valid), 64'h4);
    chk("t4_addr", 64'(mem_addr), 64'd50);
    req = '0;
    repeat (3) @(negedge clk);

    req_addr[0 +: AW] = 11'd9;
    req = 4'b0001;
    dmode = 4;
    repeat (2) @(negedge clk);
    req = '0;
    pulses = 0;
    repeat (20) begin
      pulses += int'(rsp_valid != '0);
      @(negedge clk);
    end
    chk("t5_pulses", 64'(pulses), 64'd1);
    spur = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(busy);
    end
    chk("t5_spur_busy", 64'(pulses), 64'd0);
    spur = 1'b0;

`ifdef MEM_ROW_ARB_LAST_ROW_HIT_EN
    req_addr[0 +: AW] = 11'd7;
    req = 4'b0001;
    dmode = 2;
    wait_rsp("t6_first", 40, lowc);
    first_row = rsp_data;
    chk("t6_first_row", first_row, row_of(11'd7));
    @(negedge clk);
    wait_rsp("t6_hit", 10, lowc);
    chk("t6_no_csb", 64'(lowc), 64'd0);
    chk("t6_hit_gnt", 64'(gnt), 64'h1);
    chk("t6_hit_rsp", 64'(rsp_valid), 64'h1);
    chk("t6_hit_data", rsp_data, first_row);
    req = '0;
    repeat (3) @(negedge clk);
`else
    first_row = '0;
`endif

    spur = 1'b1;
    dmode = -2;
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (e_rsp_valid[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          if (req[i]) req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        end else if (req[i] && m_owner == i && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    spur = 1'b0;
    repeat (40) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
